// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: stalls the pipeline for LATENCY+1 cycles
// per legal load/store, then releases it for one DONE cycle.
module dmem_ctrl #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        pc_rst,
  input  logic        m_memRead,
  input  logic        m_memWrite,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_writeData,
  output logic [31:0] dmem_readData,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_is_write;
  logic [31:0]           r_mem [DEPTH];
  logic                  w_req;
  logic                  w_legal;
  logic                  w_accept;
  logic                  w_access;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_idx   = m_addr[DEPTH_LOG2+1:2];
  assign w_req   = m_memRead | m_memWrite;
  assign w_legal = (m_memRead ^ m_memWrite) && (m_addr[1:0] == 2'b00) &&
                   (m_addr[31:DEPTH_LOG2+2] == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next    = r_state;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    w_accept  = 1'b0;
    w_access  = 1'b0;
    // Reset silences the handshake and suppresses any access at this edge.
    if (!pc_rst) begin
      unique case (r_state)
        IDLE: begin
          if (w_req && w_legal) begin
            mem_stall = 1'b1;
            w_accept  = 1'b1;
            w_next    = BUSY;
          end else if (w_req) begin
            mem_err = 1'b1;
          end
        end
        BUSY: begin
          mem_stall = 1'b1;
          if (r_cnt == 4'd0) begin
            w_access = 1'b1;
            w_next   = DONE;
          end
        end
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (pc_rst) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_is_write    <= 1'b0;
      dmem_readData <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt      <= CNT_LOAD;
        r_is_write <= m_memWrite;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !r_is_write) begin
        dmem_readData <= r_mem[w_idx];
      end
    end
  end

  // NOTE: the array is deliberately not reset; it keeps its contents across pc_rst.
  always_ff @(posedge clk) begin
    if (w_access && r_is_write) begin
      r_mem[w_idx] <= m_writeData;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl at LATENCY 2, 1 and 15 against
// a word-array reference model with a fixed LATENCY+1 stall budget per access.
module tb_dmem_ctrl;

  logic             clk = 1'b0;
  logic             pc_rst;
  logic [2:0]       rd, wr, stall, err;
  logic [2:0][31:0] addr, wdata, rdata;

  logic [31:0] mdl_mem [3][64];
  logic [31:0] mdl_rd  [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.LATENCY(2), .DEPTH_LOG2(6)) u_lat2 (
    .clk(clk), .pc_rst(pc_rst), .m_memRead(rd[0]), .m_memWrite(wr[0]),
    .m_addr(addr[0]), .m_writeData(wdata[0]), .dmem_readData(rdata[0]),
    .mem_stall(stall[0]), .mem_err(err[0]));

  dmem_ctrl #(.LATENCY(1), .DEPTH_LOG2(6)) u_lat1 (
    .clk(clk), .pc_rst(pc_rst), .m_memRead(rd[1]), .m_memWrite(wr[1]),
    .m_addr(addr[1]), .m_writeData(wdata[1]), .dmem_readData(rdata[1]),
    .mem_stall(stall[1]), .mem_err(err[1]));

  dmem_ctrl #(.LATENCY(15), .DEPTH_LOG2(6)) u_lat15 (
    .clk(clk), .pc_rst(pc_rst), .m_memRead(rd[2]), .m_memWrite(wr[2]),
    .m_addr(addr[2]), .m_writeData(wdata[2]), .dmem_readData(rdata[2]),
    .mem_stall(stall[2]), .mem_err(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // 64 words of 4 bytes: legal addresses are word-aligned and below 256.
  function automatic bit is_legal(input bit r, input bit w, input logic [31:0] a);
    return (r != w) && (a % 4 == 0) && (a < 32'd256);
  endfunction

  // Drops the strobes one cycle later; the block must stay quiet in IDLE.
  task automatic idle(input int d, input string tag);
    @(negedge clk);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    #1;
    check({tag, " idle stall"}, 32'(stall[d]), 32'd0);
    check({tag, " idle rdata"}, rdata[d], mdl_rd[d]);
  endtask

  // Presents a request at the next negedge and holds it until the DONE cycle;
  // strobes are left asserted through DONE so the caller may issue the next one.
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] data, input string tag);
    int n;
    @(negedge clk);
    rd[d]    = r;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = data;
    #1;
    if (!is_legal(r, w, a)) begin
      check({tag, " err"}, 32'(err[d]), 32'd1);
      check({tag, " err stall"}, 32'(stall[d]), 32'd0);
      idle(d, tag);
      return;
    end
    n = 0;
    while (stall[d] === 1'b1 && n < 40) begin
      n++;
      if (err[d] !== 1'b0) check({tag, " err in stall"}, 32'(err[d]), 32'd0);
      @(negedge clk);
      #1;
    end
    check({tag, " stall cycles"}, 32'(n), 32'(lat_of(d) + 1));
    if (r) mdl_rd[d] = mdl_mem[d][a[7:2]];
    else   mdl_mem[d][a[7:2]] = data;
    check({tag, " done err"}, 32'(err[d]), 32'd0);
    check({tag, " done rdata"}, rdata[d], mdl_rd[d]);
  endtask

  initial begin
    logic [31:0] a, data;
    bit          r, w;
    int          k;

    pc_rst = 1'b1;
    rd     = '1;
    wr     = '0;
    addr   = '0;
    wdata  = '0;
    for (int d = 0; d < 3; d++) mdl_rd[d] = 32'd0;

    // Reset with a legal request present: handshake must stay silent.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst stall%0d", d), 32'(stall[d]), 32'd0);
      check($sformatf("rst err%0d", d), 32'(err[d]), 32'd0);
      check($sformatf("rst rdata%0d", d), rdata[d], 32'd0);
    end
    pc_rst = 1'b0;
    rd     = '0;

    // Fill every word of the LATENCY=2 instance so random reads are defined.
    for (int i = 0; i < 64; i++) begin
      access(0, 1'b0, 1'b1, 32'(i * 4), $urandom, "fill");
    end
    idle(0, "fill");

    // Store then load of 0xDEADBEEF at 0x10.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "w10");
    idle(0, "w10");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "r10");
    check("r10 value", rdata[0], 32'hDEADBEEF);
    idle(0, "r10");

    // Misaligned, out of range and both strobes are all rejected.
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, "misalign");
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, "range");
    access(0, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, "both");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "after err");
    check("both no write", rdata[0], 32'hDEADBEEF);
    idle(0, "after err");

    // Reset in the first BUSY cycle aborts the pending store.
    access(0, 1'b0, 1'b1, 32'h20, 32'hA5A50020, "w20 old");
    idle(0, "w20 old");
    @(negedge clk);
    wr[0]    = 1'b1;
    addr[0]  = 32'h20;
    wdata[0] = 32'h12345678;
    #1;
    check("abort accept stall", 32'(stall[0]), 32'd1);
    @(negedge clk);
    pc_rst = 1'b1;
    #1;
    check("abort rst stall", 32'(stall[0]), 32'd0);
    check("abort rst err", 32'(err[0]), 32'd0);
    @(negedge clk);
    pc_rst = 1'b0;
    wr[0]  = 1'b0;
    for (int d = 0; d < 3; d++) mdl_rd[d] = 32'd0;
    #1;
    check("abort post stall", 32'(stall[0]), 32'd0);
    check("abort post rdata", rdata[0], 32'd0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, "r20");
    check("r20 old value", rdata[0], 32'hA5A50020);

    // Read held through DONE, then a new read next cycle: one access each.
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "held r10");
    access(0, 1'b1, 1'b0, 32'h24, 32'h0, "r24");
    idle(0, "r24");

    // Randomized mix of legal and illegal requests.
    for (int i = 0; i < 80; i++) begin
      k    = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 63)) << 2;
      r    = 1'($urandom_range(0, 1));
      w    = !r;
      data = $urandom;
      if (k == 0)      a = a | 32'($urandom_range(1, 3));
      else if (k == 1) a = a | (32'h1 << $urandom_range(8, 31));
      else if (k == 2) begin r = 1'b1; w = 1'b1; end
      access(0, r, w, a, data, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle(0, "rnd");
    end
    idle(0, "rnd end");

    // Latency extremes.
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        a    = 32'($urandom_range(0, 63)) << 2;
        data = $urandom;
        access(d, 1'b0, 1'b1, a, data, $sformatf("lat%0d w%0d", lat_of(d), i));
        access(d, 1'b1, 1'b0, a, 32'h0, $sformatf("lat%0d r%0d", lat_of(d), i));
        check($sformatf("lat%0d val%0d", lat_of(d), i), rdata[d], data);
        idle(d, "lat");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
